// File: rtl/game_pkg.sv
// Shared types and constants for the game round controller and its win checker.
package game_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StSettle = 3'd1,
    StPlay   = 3'd2,
    StWin    = 3'd3,
    StLose   = 3'd4,
    StDone   = 3'd5
  } state_e;

  localparam int unsigned NumCellsDefault = 32;

  localparam logic [31:0] WinAllZero = 32'h0000_0000;
  localparam logic [31:0] WinAllOne  = 32'hFFFF_FFFF;
  localparam logic [31:0] WinOdd     = 32'h5555_5555;
  localparam logic [31:0] WinEven    = 32'hAAAA_AAAA;

  function automatic logic is_win_pattern(input logic [31:0] s);
    return (s == WinAllZero) || (s == WinAllOne) || (s == WinOdd) || (s == WinEven);
  endfunction

endpackage

// File: rtl/buzz_timer.sv
// Buzzer timer: a load pulse raises the level for exactly CYCLES cycles; done marks the last one.
module buzz_timer #(
  parameter int unsigned CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic done,
  output logic level
);
  localparam int unsigned CntW = $clog2(CYCLES + 1);

  logic [CntW-1:0] cnt_q;
  logic            level_q;

  assign done  = level_q && (cnt_q == '0);
  assign level = level_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else if (load) begin
      cnt_q   <= CntW'(CYCLES - 1);
      level_q <= 1'b1;
    end else if (level_q) begin
      if (cnt_q == '0) begin
        level_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/game_round_ctrl.sv
// Round sequencer: loads a seed, applies player toggles, waits out the checker, then buzzes or
// declares a loss.
module game_round_ctrl
  import game_pkg::*;
#(
  parameter int unsigned NUM_CELLS   = NumCellsDefault,
  parameter int unsigned IDX_W       = 5,
  parameter int unsigned CHECK_LAT   = 2,
  parameter int unsigned MAX_MOVES   = 16,
  parameter int unsigned BUZZ_CYCLES = 50000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NUM_CELLS-1:0] seed,
  input  logic                 move_valid,
  input  logic [IDX_W-1:0]     move_idx,
  input  logic                 win_in,
  output logic [NUM_CELLS-1:0] screen_values,
  output logic                 move_ready,
  output logic [7:0]           move_count,
  output logic                 buzz,
  output logic                 won,
  output logic                 lost,
  output logic                 busy
);
  localparam logic [2:0]           SettleLast = 3'(CHECK_LAT - 1);
  localparam logic [7:0]           MoveBudget = 8'(MAX_MOVES);
  localparam logic [NUM_CELLS-1:0] CellOne    = NUM_CELLS'(1);

  state_e               state_q, state_d;
  logic [NUM_CELLS-1:0] screen_q;
  logic [7:0]           count_q;
  logic [2:0]           settle_q;
  logic                 won_q, lost_q;
  logic                 idx_ok, start_take, move_take, settle_last, buzz_load, buzz_done;
  logic                 lose_enter;

  assign idx_ok      = 32'(move_idx) < NUM_CELLS;
  assign start_take  = start && ((state_q == StIdle) || (state_q == StDone));
  assign move_take   = move_valid && move_ready && idx_ok;
  assign settle_last = (state_q == StSettle) && (settle_q == SettleLast);
  // Win is checked before the budget so a winning final move still wins.
  assign buzz_load   = settle_last && win_in;
  assign lose_enter  = settle_last && !win_in && (count_q == MoveBudget);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: if (start_take) state_d = StSettle;
      StSettle: begin
        if (buzz_load)       state_d = StWin;
        else if (lose_enter) state_d = StLose;
        else if (settle_last) state_d = StPlay;
      end
      StPlay:  if (move_take) state_d = StSettle;
      StWin:   if (buzz_done) state_d = StDone;
      StLose:  state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    move_ready = (state_q == StPlay);
    busy       = !((state_q == StIdle) || (state_q == StDone));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      screen_q <= '0;
      count_q  <= '0;
      settle_q <= '0;
      won_q    <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      if (start_take) begin
        screen_q <= seed;
        count_q  <= '0;
        settle_q <= '0;
        won_q    <= 1'b0;
        lost_q   <= 1'b0;
      end else if (move_take) begin
        screen_q <= screen_q ^ (CellOne << move_idx);
        if (count_q != MoveBudget) count_q <= count_q + 8'd1;
        settle_q <= '0;
      end else if (state_q == StSettle) begin
        settle_q <= settle_q + 3'd1;
      end
      if (buzz_load)  won_q  <= 1'b1;
      if (lose_enter) lost_q <= 1'b1;
    end
  end

  buzz_timer #(
    .CYCLES(BUZZ_CYCLES)
  ) u_buzz_timer (
    .clk  (clk),
    .reset(reset),
    .load (buzz_load),
    .done (buzz_done),
    .level(buzz)
  );

  assign screen_values = screen_q;
  assign move_count    = count_q;
  assign won           = won_q;
  assign lost          = lost_q;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Self-checking bench for game_round_ctrl with a one-cycle registered win-checker model.
module tb_game_round_ctrl;
  import game_pkg::*;

  localparam int unsigned NC = 32;
  localparam int unsigned IW = 5;

  logic          clk = 1'b0, reset = 1'b1, start = 1'b0, move_valid = 1'b0, win_in = 1'b0;
  logic [NC-1:0] seed = '0;
  logic [IW-1:0] move_idx = '0;
  logic [NC-1:0] screen_values;
  logic [7:0]    move_count;
  logic          move_ready, buzz, won, lost, busy;

  logic          start_n = 1'b0, move_valid_n = 1'b0, win_n = 1'b0;
  logic [23:0]   seed_n = '0, screen_n;
  logic [IW-1:0] idx_n = '0;
  logic [7:0]    count_n;
  logic          ready_n, buzz_n, won_n, lost_n, busy_n;

  typedef struct packed {
    logic        won;
    logic        lost;
    logic [7:0]  count;
    logic [31:0] screen;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   buzz_hi_cnt = 0;
  int   ready_hi_cnt = 0;

  game_round_ctrl #(
    .NUM_CELLS(NC), .IDX_W(IW), .CHECK_LAT(2), .MAX_MOVES(3), .BUZZ_CYCLES(4)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .seed(seed), .move_valid(move_valid),
    .move_idx(move_idx), .win_in(win_in), .screen_values(screen_values),
    .move_ready(move_ready), .move_count(move_count), .buzz(buzz), .won(won), .lost(lost),
    .busy(busy)
  );

  game_round_ctrl #(
    .NUM_CELLS(24), .IDX_W(IW), .CHECK_LAT(2), .MAX_MOVES(3), .BUZZ_CYCLES(4)
  ) dut_narrow (
    .clk(clk), .reset(reset), .start(start_n), .seed(seed_n), .move_valid(move_valid_n),
    .move_idx(idx_n), .win_in(win_n), .screen_values(screen_n),
    .move_ready(ready_n), .move_count(count_n), .buzz(buzz_n), .won(won_n), .lost(lost_n),
    .busy(busy_n)
  );

  function automatic logic win24(input logic [23:0] s);
    return (s == 24'h000000) || (s == 24'hFFFFFF) || (s == 24'h555555) || (s == 24'hAAAAAA);
  endfunction

  always #5 clk = ~clk;

  // Registered checker model: win flag valid one cycle after the screen changes.
  always @(posedge clk) begin
    win_in <= is_win_pattern(screen_values);
    win_n  <= win24(screen_n);
  end

  always @(negedge clk) begin
    if (buzz) buzz_hi_cnt++;
    if (move_ready) ready_hi_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 0; i < 30 && !move_ready; i++) tick();
    if (!move_ready) begin
      n_tests++; n_fail++;
      $display("FAIL %s_ready: move_ready=0 after 30 cycles, need 1", tag);
    end
  endtask

  task automatic do_move(input logic [IW-1:0] idx, input string tag);
    wait_ready(tag);
    move_valid = 1'b1;
    move_idx   = idx;
    tick();
    move_valid = 1'b0;
  endtask

  task automatic start_round(input logic [NC-1:0] s, input exp_t e);
    seed  = s;
    start = 1'b1;
    exp_q.push_back(e);
    tick();
    start = 1'b0;
  endtask

  task automatic finish_round(input string tag);
    exp_t e, got;
    for (int i = 0; i < 60 && busy; i++) tick();
    got = '{won: won, lost: lost, count: move_count, screen: screen_values};
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: round ended with no expected result queued", tag);
    end else begin
      e = exp_q.pop_front();
      if (busy !== 1'b0 || got !== e) begin
        n_fail++;
        $display("FAIL %s: got busy=%0b won=%0b lost=%0b count=%0d screen=%h, need busy=0 won=%0b lost=%0b count=%0d screen=%h",
                 tag, busy, got.won, got.lost, got.count, got.screen, e.won, e.lost, e.count,
                 e.screen);
      end
    end
  endtask

  task automatic test_reset();
    tick(); tick();
    n_tests++;
    if (dut.state_q !== StIdle || screen_values !== '0 || move_count !== 8'd0 ||
        {buzz, won, lost, move_ready, busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_state: got state=%0d screen=%h count=%0d flags=%b, need 0 0 0 00000",
               dut.state_q, screen_values, move_count, {buzz, won, lost, move_ready, busy});
    end
    reset = 1'b0;
    seed  = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10 && !buzz; i++) tick();
    n_tests++;
    if (buzz !== 1'b1 || won !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pre_win: got buzz=%0b won=%0b, need 1 1", buzz, won);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_tests++;
    if (buzz !== 1'b0 || dut.state_q !== StIdle || screen_values !== '0 || won !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_win: got buzz=%0b state=%0d screen=%h won=%0b, need 0 0 0 0",
               buzz, dut.state_q, screen_values, won);
    end
  endtask

  task automatic test_win_move();
    int hi;
    start_round(32'hFFFF_FFFE, '{won: 1'b1, lost: 1'b0, count: 8'd1, screen: 32'hFFFF_FFFF});
    do_move(5'd0, "win");
    n_tests++;
    if (screen_values !== 32'hFFFF_FFFF || move_count !== 8'd1) begin
      n_fail++;
      $display("FAIL win_move: got screen=%h count=%0d, need ffffffff 1", screen_values,
               move_count);
    end
    tick(); tick();
    n_tests++;
    if (dut.state_q !== StWin || buzz !== 1'b1) begin
      n_fail++;
      $display("FAIL win_latency: got state=%0d buzz=%0b, need 3 1", dut.state_q, buzz);
    end
    hi = buzz ? 1 : 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!buzz) break;
      hi++;
    end
    n_tests++;
    if (hi !== 4) begin
      n_fail++;
      $display("FAIL buzz_len: got %0d cycles, need 4", hi);
    end
    n_tests++;
    if (dut.state_q !== StDone) begin
      n_fail++;
      $display("FAIL win_done: got state=%0d, need 5", dut.state_q);
    end
    finish_round("win_round");
  endtask

  task automatic test_lose();
    int b0;
    b0 = buzz_hi_cnt;
    start_round(32'h0000_0001, '{won: 1'b0, lost: 1'b1, count: 8'd3, screen: 32'h0000_00E1});
    do_move(5'd5, "lose");
    do_move(5'd6, "lose");
    do_move(5'd7, "lose");
    finish_round("lose_round");
    n_tests++;
    if (buzz_hi_cnt !== b0) begin
      n_fail++;
      $display("FAIL lose_buzz: got %0d buzz cycles, need 0", buzz_hi_cnt - b0);
    end
  endtask

  task automatic test_top_bit_and_drops();
    start_round(32'h1234_5678, '{won: 1'b0, lost: 1'b1, count: 8'd3, screen: 32'h9234_567B});
    do_move(5'd31, "top");
    n_tests++;
    if (screen_values !== 32'h9234_5678 || move_count !== 8'd1) begin
      n_fail++;
      $display("FAIL top_bit: got screen=%h count=%0d, need 92345678 1", screen_values,
               move_count);
    end
    move_valid = 1'b1;
    move_idx   = 5'd0;
    tick();
    move_valid = 1'b0;
    n_tests++;
    if (screen_values !== 32'h9234_5678 || move_count !== 8'd1) begin
      n_fail++;
      $display("FAIL drop_settle: got screen=%h count=%0d, need 92345678 1", screen_values,
               move_count);
    end
    wait_ready("drops");
    seed  = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_tests++;
    if (screen_values !== 32'h9234_5678 || move_count !== 8'd1 || move_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL start_in_play: got screen=%h count=%0d ready=%0b, need 92345678 1 1",
               screen_values, move_count, move_ready);
    end
    do_move(5'd0, "drops");
    do_move(5'd1, "drops");
    finish_round("drops_round");
    move_valid = 1'b1;
    move_idx   = 5'd2;
    tick();
    move_valid = 1'b0;
    n_tests++;
    if (screen_values !== 32'h9234_567B || move_count !== 8'd3 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_done: got screen=%h count=%0d busy=%0b, need 9234567b 3 0",
               screen_values, move_count, busy);
    end
  endtask

  task automatic test_seed_win();
    int r0;
    r0 = ready_hi_cnt;
    // Move arriving together with start must be ignored.
    move_valid = 1'b1;
    move_idx   = 5'd0;
    start_round(32'h5555_5555, '{won: 1'b1, lost: 1'b0, count: 8'd0, screen: 32'h5555_5555});
    move_valid = 1'b0;
    finish_round("seed_win_round");
    n_tests++;
    if (ready_hi_cnt !== r0) begin
      n_fail++;
      $display("FAIL seed_win_ready: got %0d ready cycles, need 0", ready_hi_cnt - r0);
    end
  endtask

  task automatic test_final_move_win();
    start_round(32'h0000_0007, '{won: 1'b1, lost: 1'b0, count: 8'd3, screen: 32'h0000_0000});
    do_move(5'd0, "final");
    do_move(5'd1, "final");
    do_move(5'd2, "final");
    finish_round("final_move_win");
  endtask

  task automatic test_narrow();
    seed_n  = 24'h345678;
    start_n = 1'b1;
    tick();
    start_n = 1'b0;
    for (int i = 0; i < 30 && !ready_n; i++) tick();
    n_tests++;
    if (ready_n !== 1'b1) begin
      n_fail++;
      $display("FAIL narrow_ready: got %0b, need 1", ready_n);
    end
    move_valid_n = 1'b1;
    idx_n        = 5'd30;
    tick();
    move_valid_n = 1'b0;
    n_tests++;
    if (screen_n !== 24'h345678 || count_n !== 8'd0 || ready_n !== 1'b1) begin
      n_fail++;
      $display("FAIL narrow_oob: got screen=%h count=%0d ready=%0b, need 345678 0 1",
               screen_n, count_n, ready_n);
    end
    move_valid_n = 1'b1;
    idx_n        = 5'd23;
    tick();
    move_valid_n = 1'b0;
    n_tests++;
    if (screen_n !== 24'hB45678 || count_n !== 8'd1) begin
      n_fail++;
      $display("FAIL narrow_top: got screen=%h count=%0d, need b45678 1", screen_n, count_n);
    end
  endtask

  initial begin
    test_reset();
    test_win_move();
    test_lose();
    test_top_bit_and_drops();
    test_seed_win();
    test_final_move_win();
    test_narrow();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
